muldiv_unit: RTL

Multiply/divide unit for the five-stage MIPS pipeline. It sits in the E stage, directly downstream of the E-stage forwarding muxes, and takes the already-forwarded rs/rt operands for mult, multu, div, divu, mthi and mtlo. It owns the HI/LO registers, models the multi-cycle latency with a busy counter, and exposes `busy` so the stall unit can hold D-stage mfhi/mflo/mult/div/mthi/mtlo instructions.

---
 rtl/muldiv_pkg.sv | 22 ++
 rtl/muldiv_unit.sv | 133 +++++++++++++
 2 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings for the E-stage multiply/divide unit: op codes,
// default latencies and FSM state encoding.
package muldiv_pkg;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/muldiv_unit.sv
// HI/LO owner for the MIPS E stage: computes mult/div results at issue,
// holds them for a fixed busy period, then commits them to HI/LO.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic [31:0]      hi_q, lo_q;
    logic [31:0]      pend_hi_q, pend_lo_q;
    logic             pend_wr_q;

    logic [31:0]      pend_hi_d, pend_lo_d;
    logic             pend_wr_d;

    logic [63:0]      prod_s, prod_u;
    logic [31:0]      b_nz, a_mag, b_mag, q_mag, r_mag, q_s, r_s, q_u, r_u;

    assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign prod_u = {32'd0, a} * {32'd0, b};

    // Divide on magnitudes so the 0x80000000 / -1 case wraps to 0x80000000
    // instead of relying on signed-overflow behaviour of the operator.
    assign b_nz  = (b == 32'd0) ? 32'd1 : b;
    assign a_mag = a[31] ? -a : a;
    assign b_mag = b_nz[31] ? -b_nz : b_nz;
    assign q_mag = a_mag / b_mag;
    assign r_mag = a_mag % b_mag;
    assign q_s   = (a[31] ^ b_nz[31]) ? -q_mag : q_mag;
    assign r_s   = a[31] ? -r_mag : r_mag;
    assign q_u   = a / b_nz;
    assign r_u   = a % b_nz;

    always_comb begin
        pend_hi_d = 32'd0;
        pend_lo_d = 32'd0;
        pend_wr_d = 1'b0;
        case (op)
            OP_MULT: begin
                pend_hi_d = prod_s[63:32];
                pend_lo_d = prod_s[31:0];
                pend_wr_d = 1'b1;
            end
            OP_MULTU: begin
                pend_hi_d = prod_u[63:32];
                pend_lo_d = prod_u[31:0];
                pend_wr_d = 1'b1;
            end
            OP_DIV: begin
                pend_hi_d = r_s;
                pend_lo_d = q_s;
                pend_wr_d = (b != 32'd0);
            end
            OP_DIVU: begin
                pend_hi_d = r_u;
                pend_lo_d = q_u;
                pend_wr_d = (b != 32'd0);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            pend_wr_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        case (op)
                            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                                state_q   <= ST_RUN;
                                busy_q    <= 1'b1;
                                cnt_q     <= (op == OP_MULT || op == OP_MULTU)
                                             ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                                pend_hi_q <= pend_hi_d;
                                pend_lo_q <= pend_lo_d;
                                pend_wr_q <= pend_wr_d;
                            end
                            OP_MTHI: hi_q <= a;
                            OP_MTLO: lo_q <= a;
                            default: ;
                        endcase
                    end
                end
                ST_RUN: begin
                    // start is deliberately not looked at here, commit cycle included
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                        if (pend_wr_q) begin
                            hi_q <= pend_hi_q;
                            lo_q <= pend_lo_q;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
